// File: rtl/pipelined_cla_adder_pkg.sv
// Purpose : shared constants, types and configuration check for the pipelined CLA adder.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: CLA_GROUP lookahead group width, cla_pg_t group propagate/generate pair,
//           sw_ok() legality check for a WIDTH/STAGES pairing.
package adder_pkg;

   localparam int CLA_GROUP = 4;

   // Group propagate / generate pair produced by one lookahead group.
   typedef struct packed {
      logic p;
      logic g;
   } cla_pg_t;

   // A legal configuration splits WIDTH into STAGES equal slices, each a whole
   // number of lookahead groups, with STAGES in 1..8.
   function automatic bit sw_ok(input int width, input int stages);
      return (stages >= 1) && (stages <= 8) && (width > 0) &&
             ((width % (CLA_GROUP * stages)) == 0);
   endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_group_4b.sv
// Purpose : 4-bit carry-lookahead group: sum bits plus group propagate/generate.
// Latency : combinational.
// Backpressure: none (pure logic).
// Ports   : a, b [3:0] operands; cin carry into bit 0; sum [3:0]; pg group P/G.
module cla_group_4b
   import adder_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output cla_pg_t    pg
);

   logic [3:0] p;
   logic [3:0] g;
   logic [3:0] c;

   assign p = a ^ b;
   assign g = a & b;

   // Every internal carry is a flat sum-of-products of cin, p and g; no ripple.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

   assign sum  = p ^ c;

   // Group P/G exclude cin so the enclosing slice can chain groups itself.
   assign pg.p = &p;
   assign pg.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/pipelined_cla_adder.sv
// Purpose : pipelined WIDTH-bit carry-lookahead add/subtract, one SW-bit slice per stage.
// Latency : STAGES cycles from input transfer to out_valid when not stalled.
// Backpressure: valid/ready; a stage loads when empty or its successor loads, so
//           bubbles are squeezed out and in_ready falls only when every stage is full.
// Ports   : clk, rst_n (async active-low); in_valid/in_ready, in_a, in_b, in_cin, in_sub;
//           out_valid/out_ready, out_sum, out_cout (sub: 1 = no borrow), out_ovf (signed).
module pipelined_cla_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int SW = WIDTH / STAGES;
   localparam int NG = SW / CLA_GROUP;

   if (!sw_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipelined_cla_adder: WIDTH must be a multiple of 4*STAGES and STAGES in 1..8");
   end

   logic [WIDTH-1:0]  b_eff;
   logic              c_eff;
   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] ld;
   logic [STAGES-1:0] vin;

   // Subtraction is A + ~B + 1; a requested carry-in turns that into A - B - 1.
   assign b_eff = in_sub ? ~in_b : in_b;
   assign c_eff = in_cin ^ in_sub;

   // Handshake: load enables propagate backwards from the consumer, so in_ready
   // depends only on the valid chain and out_ready, never on in_valid.
   always_comb begin
      ld  = '0;
      vin = '0;
      ld[STAGES-1] = !vld_q[STAGES-1] || out_ready;
      for (int k = STAGES - 2; k >= 0; k--) begin
         ld[k] = !vld_q[k] || ld[k+1];
      end
      vin[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         vin[k] = vld_q[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (ld[k]) vld_q[k] <= vin[k];
         end
      end
   end

   assign in_ready  = ld[0];
   assign out_valid = vld_q[STAGES-1];

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      // Operand bits still to be added once this stage has done its slice.
      localparam int REM = WIDTH - (k + 1) * SW;

      logic [SW-1:0]         sa;
      logic [SW-1:0]         sb;
      logic [SW-1:0]         ss;
      logic [NG:0]           gc;
      cla_pg_t               pg [NG];
      logic [(k+1)*SW-1:0]   sum_d;
      logic [(k+1)*SW-1:0]   sum_q;
      logic                  cy_q;
      logic                  ld_dat;

      // Data only moves with a real beat, so idle stages keep their last contents.
      assign ld_dat = ld[k] & vin[k];

      if (k == 0) begin : g_src
         assign sa    = in_a[SW-1:0];
         assign sb    = b_eff[SW-1:0];
         assign gc[0] = c_eff;
         assign sum_d = ss;
      end else begin : g_src
         // Low SW bits of the forwarded operands are exactly this stage's slice.
         assign sa    = g_st[k-1].g_fwd.a_q[SW-1:0];
         assign sb    = g_st[k-1].g_fwd.b_q[SW-1:0];
         assign gc[0] = g_st[k-1].cy_q;
         assign sum_d = {ss, g_st[k-1].sum_q};
      end

      // Groups chain through their P/G terms inside the slice.
      for (genvar gi = 0; gi < NG; gi++) begin : g_grp
         cla_group_4b u_grp (
            .a   (sa[gi*CLA_GROUP +: CLA_GROUP]),
            .b   (sb[gi*CLA_GROUP +: CLA_GROUP]),
            .cin (gc[gi]),
            .sum (ss[gi*CLA_GROUP +: CLA_GROUP]),
            .pg  (pg[gi])
         );
         assign gc[gi+1] = pg[gi].g | (pg[gi].p & gc[gi]);
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sum_q <= '0;
            cy_q  <= 1'b0;
         end else if (ld_dat) begin
            sum_q <= sum_d;
            cy_q  <= gc[NG];
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [REM-1:0] a_d;
         logic [REM-1:0] b_d;
         logic [REM-1:0] a_q;
         logic [REM-1:0] b_q;

         if (k == 0) begin : g_fsrc
            assign a_d = in_a[WIDTH-1:SW];
            assign b_d = b_eff[WIDTH-1:SW];
         end else begin : g_fsrc
            assign a_d = g_st[k-1].g_fwd.a_q[REM+SW-1:SW];
            assign b_d = g_st[k-1].g_fwd.b_q[REM+SW-1:SW];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (ld_dat) begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end else begin : g_last
         logic ovf_q;

         // Carry into the MSB is recovered from its sum bit; overflow is that
         // carry disagreeing with the carry out of the MSB.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (ld_dat) begin
               ovf_q <= ss[SW-1] ^ sa[SW-1] ^ sb[SW-1] ^ gc[NG];
            end
         end

         assign out_sum  = sum_q;
         assign out_cout = cy_q;
         assign out_ovf  = ovf_q;
      end
   end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Purpose : directed and streamed checks of pipelined_cla_adder in three configurations
//           (32/2, 32/1, 64/4), one active at a time through a shared stimulus bus.
// Latency : n/a.  Backpressure: out_ready driven by the bench.
module tb_pipelined_cla_adder;

   typedef struct packed {
      logic [63:0] s;
      logic        c;
      logic        o;
   } res_t;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] s32;
      logic        c32;
      logic        o32;
      logic [63:0] s64;
      logic        c64;
      logic        o64;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_cin;
   logic        in_sub;
   logic        out_ready;
   logic [63:0] in_a;
   logic [63:0] in_b;
   int          cfg;
   int          W;
   int          S;
   int          n_cmp;
   int          n_err;

   logic [2:0]  vld_i;
   logic [2:0]  rdy_o;
   logic [2:0]  ov_o;
   logic [2:0]  cout_o;
   logic [2:0]  ovf_o;
   logic [31:0] sum0;
   logic [31:0] sum1;
   logic [63:0] sum2;

   logic        t_in_ready;
   logic        t_out_valid;
   logic [63:0] t_sum;
   logic        t_cout;
   logic        t_ovf;

   assign vld_i[0] = in_valid && (cfg == 0);
   assign vld_i[1] = in_valid && (cfg == 1);
   assign vld_i[2] = in_valid && (cfg == 2);

   pipelined_cla_adder #(.WIDTH(32), .STAGES(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld_i[0]), .in_ready(rdy_o[0]),
      .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(ov_o[0]), .out_ready(out_ready), .out_sum(sum0),
      .out_cout(cout_o[0]), .out_ovf(ovf_o[0]));

   pipelined_cla_adder #(.WIDTH(32), .STAGES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld_i[1]), .in_ready(rdy_o[1]),
      .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(ov_o[1]), .out_ready(out_ready), .out_sum(sum1),
      .out_cout(cout_o[1]), .out_ovf(ovf_o[1]));

   pipelined_cla_adder #(.WIDTH(64), .STAGES(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld_i[2]), .in_ready(rdy_o[2]),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(ov_o[2]), .out_ready(out_ready), .out_sum(sum2),
      .out_cout(cout_o[2]), .out_ovf(ovf_o[2]));

   always_comb begin
      t_in_ready  = rdy_o[0];
      t_out_valid = ov_o[0];
      t_sum       = {32'd0, sum0};
      t_cout      = cout_o[0];
      t_ovf       = ovf_o[0];
      case (cfg)
         1: begin
            t_in_ready = rdy_o[1]; t_out_valid = ov_o[1]; t_sum = {32'd0, sum1};
            t_cout = cout_o[1]; t_ovf = ovf_o[1];
         end
         2: begin
            t_in_ready = rdy_o[2]; t_out_valid = ov_o[2]; t_sum = sum2;
            t_cout = cout_o[2]; t_ovf = ovf_o[2];
         end
         default: ;
      endcase
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, cfg=%0d", cfg);
      $fatal(1, "watchdog");
   end

   // Independent reference: plain wide addition, overflow from operand/result signs.
   function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, input logic sub, input int w);
      res_t        r;
      logic [63:0] m;
      logic [63:0] be;
      logic [64:0] full;
      m    = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      be   = (sub ? ~b : b) & m;
      full = {1'b0, a & m} + {1'b0, be} + {64'd0, cin ^ sub};
      r.s  = full[63:0] & m;
      r.c  = full[w];
      r.o  = (a[w-1] == be[w-1]) && (r.s[w-1] != a[w-1]);
      return r;
   endfunction

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s (cfg %0d W=%0d S=%0d): got %h, expected %h", nm, cfg, W, S, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   // One isolated beat: checks acceptance, exact latency and the result.
   task automatic send_one(input string nm, input logic [63:0] a, input logic [63:0] b,
                           input logic cin, input logic sub,
                           input logic [63:0] es, input logic ec, input logic eo);
      int lat;
      out_ready = 1'b1;
      in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
      #1;
      check({nm, "_in_ready"}, {63'd0, t_in_ready}, 64'd1);
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!t_out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({nm, "_latency"}, 64'(lat), 64'(S));
      check({nm, "_sum"}, t_sum, es);
      check({nm, "_cout_ovf"}, {62'd0, t_cout, t_ovf}, {62'd0, ec, eo});
      tick();
      check({nm, "_drained"}, {63'd0, t_out_valid}, 64'd0);
   endtask

   task automatic run_stream();
      res_t        q[$];
      res_t        e;
      int          sent;
      int          got;
      int          cyc;
      logic        stall;
      logic [63:0] hs;
      logic        hc;
      logic        ho;
      sent = 0; got = 0; cyc = 0; stall = 1'b0; hs = '0; hc = 1'b0; ho = 1'b0;
      while (got < 100 && cyc < 3000) begin
         if (stall) begin
            check("stall_sum", t_sum, hs);
            check("stall_flags", {61'd0, t_out_valid, t_cout, t_ovf}, {61'd0, 1'b1, hc, ho});
         end
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = (sent < 100);
         in_a      = {$urandom, $urandom};
         in_b      = {$urandom, $urandom};
         in_cin    = 1'($urandom_range(0, 1));
         in_sub    = 1'($urandom_range(0, 1));
         #1;
         if (in_valid && t_in_ready) begin
            q.push_back(model(in_a, in_b, in_cin, in_sub, W));
            sent++;
         end
         if (t_out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL stream_extra (cfg %0d): result beat with nothing outstanding, sum %h", cfg, t_sum);
            end else begin
               e = q.pop_front();
               check("stream_sum", t_sum, e.s);
               check("stream_flags", {62'd0, t_cout, t_ovf}, {62'd0, e.c, e.o});
            end
            got++;
         end
         stall = t_out_valid && !out_ready;
         hs = t_sum; hc = t_cout; ho = t_ovf;
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("stream_count", 64'(got), 64'd100);
      check("stream_outstanding", 64'(q.size()), 64'd0);
      repeat (S + 2) tick();
      check("stream_no_dup", {63'd0, t_out_valid}, 64'd0);
   endtask

   task automatic run_fill();
      res_t q[$];
      res_t e;
      int   acc;
      acc = 0;
      out_ready = 1'b0;
      in_cin = 1'b0; in_sub = 1'b0;
      for (int i = 0; i < S + 3; i++) begin
         in_valid = 1'b1;
         in_a = 64'h1111 * 64'(i + 1);
         in_b = 64'(i);
         #1;
         if (!t_in_ready) break;
         q.push_back(model(in_a, in_b, in_cin, in_sub, W));
         acc++;
         tick();
      end
      in_valid = 1'b0;
      check("fill_accepted", 64'(acc), 64'(S));
      check("fill_in_ready_low", {63'd0, t_in_ready}, 64'd0);
      check("fill_out_valid", {63'd0, t_out_valid}, 64'd1);
      repeat (2) tick();
      check("fill_hold_sum", t_sum, q[0].s);
      out_ready = 1'b1;
      #1;
      check("fill_release_in_ready", {63'd0, t_in_ready}, 64'd1);
      for (int j = 0; j < S; j++) begin
         e = q.pop_front();
         check("drain_valid", {63'd0, t_out_valid}, 64'd1);
         check("drain_sum", t_sum, e.s);
         tick();
      end
      check("drain_empty", {63'd0, t_out_valid}, 64'd0);
   endtask

   task automatic run_reset_mid();
      out_ready = 1'b0;
      in_cin = 1'b0; in_sub = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_a = 64'hABCD_0000 + 64'(i);
         in_b = 64'h1234;
         #1;
         if (!t_in_ready) break;
         tick();
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rstmid_out_valid", {63'd0, t_out_valid}, 64'd0);
      check("rstmid_out_sum", t_sum, 64'd0);
      check("rstmid_flags", {62'd0, t_cout, t_ovf}, 64'd0);
      check("rstmid_in_ready", {63'd0, t_in_ready}, 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      send_one("post_reset", 64'hFF, 64'h01, 1'b0, 1'b0, 64'h100, 1'b0, 1'b0);
   endtask

   vec_t tbl [9];

   initial begin
      n_cmp = 0; n_err = 0;
      cfg = 0; W = 32; S = 2;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;

      //         a                       b                       cin   sub   s32           c32   o32   s64                     c64   o64
      tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 64'h0000_0000_0000_0000, 1'b1, 1'b0};
      tbl[1] = '{64'd5,                   64'd7,                  1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      tbl[2] = '{64'h8000_0000_8000_0000, 64'd1,                  1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 64'h8000_0000_7FFF_FFFF, 1'b1, 1'b0};
      tbl[3] = '{64'h8000_0000_0000_0000, 64'd1,                  1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      tbl[4] = '{64'h4000_0000_4000_0000, 64'h4000_0000_4000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 64'h8000_0000_8000_0000, 1'b0, 1'b1};
      tbl[5] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 32'h2222_2212, 1'b1, 1'b1, 64'h2222_2222_2222_2212, 1'b0, 1'b0};
      tbl[6] = '{64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 64'h0000_0000_0000_0000, 1'b1, 1'b0};
      tbl[7] = '{64'd10,                  64'd3,                  1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0, 64'h0000_0000_0000_0006, 1'b1, 1'b0};
      tbl[8] = '{64'hFFFF_FFFF_0000_FFFF, 64'd1,                  1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 64'hFFFF_FFFF_0001_0000, 1'b0, 1'b0};

      for (int ci = 0; ci < 3; ci++) begin
         cfg = ci;
         W   = (ci == 2) ? 64 : 32;
         S   = (ci == 0) ? 2 : (ci == 1) ? 1 : 4;
         do_reset();

         check("reset_out_valid", {63'd0, t_out_valid}, 64'd0);
         check("reset_out_sum", t_sum, 64'd0);
         check("reset_flags", {62'd0, t_cout, t_ovf}, 64'd0);
         check("reset_in_ready", {63'd0, t_in_ready}, 64'd1);

         for (int i = 0; i < 9; i++) begin
            if (W == 64)
               send_one($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
                        tbl[i].s64, tbl[i].c64, tbl[i].o64);
            else
               send_one($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
                        {32'd0, tbl[i].s32}, tbl[i].c32, tbl[i].o32);
         end

         run_stream();
         run_fill();
         run_reset_mid();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
